psa_pipe: RTL and testbench

Pipelined, parametrised partitioned SIMD adder/subtractor that follows the fixed 16-bit, 4-lane combinational partitioned adder. It splits two W-bit operands into LANES independent two's-complement lanes of LANE_W bits each. Every lane can add or subtract, with optional per-lane saturation and a per-lane overflow flag. It sits in the execute path behind a valid/ready handshake and keeps a sticky error flag for the control unit.

---
 rtl/psa_pkg.sv | 17 +
 rtl/psa_lane.sv | 33 +++
 rtl/psa_pipe.sv | 124 ++++++++++++
 tb/tb_psa_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// Shared defaults and saturation constants for the psa_pipe partitioned adder.
package psa_pkg;

  localparam int LANE_W_DEF = 4;
  localparam int LANES_DEF  = 4;

  // Largest positive two's-complement value of a w-bit lane (0111...)
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit lane (1000...)
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/psa_lane.sv
// One combinational signed add/sub lane with overflow detect and optional saturation.
module psa_lane
  import psa_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [LANE_W-1:0] res,
  output logic              ovfl
);

  localparam logic [LANE_W-1:0] MAXV = LANE_W'(sat_max(LANE_W));
  localparam logic [LANE_W-1:0] MINV = LANE_W'(sat_min(LANE_W));

  logic [LANE_W-1:0] bb_s;
  logic [LANE_W-1:0] raw_s;

  // Subtraction is a + ~b + 1; overflow when both addends share a sign the result lacks
  always_comb begin
    bb_s  = sub ? ~b : b;
    raw_s = a + bb_s + {{(LANE_W-1){1'b0}}, sub};
    ovfl  = (a[LANE_W-1] == bb_s[LANE_W-1]) && (raw_s[LANE_W-1] != a[LANE_W-1]);
    if (ovfl && sat) begin
      res = a[LANE_W-1] ? MINV : MAXV;
    end else begin
      res = raw_s;
    end
  end

endmodule

// File: rtl/psa_pipe.sv
// Two-stage valid/ready partitioned SIMD adder/subtractor with sticky overflow error.
// Optional PSA_PIPE_OVFL_CNT_EN adds a saturating 16-bit overflow-transfer counter.
module psa_pipe
  import psa_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   a,
  input  logic [LANE_W*LANES-1:0]   b,
  input  logic                      sub,
  input  logic                      sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   sum,
  output logic [LANES-1:0]          lane_ovfl,
  input  logic                      clr_err,
  output logic                      error
`ifdef PSA_PIPE_OVFL_CNT_EN
  ,
  output logic [15:0]               ovfl_cnt
`endif
);

  localparam int W = LANE_W * LANES;

  logic          s1_valid_r;
  logic [W-1:0]  s1_a_r;
  logic [W-1:0]  s1_b_r;
  logic          s1_sub_r;
  logic          s1_sat_r;
  logic [W-1:0]  res_s;
  logic [LANES-1:0] ovfl_s;
  logic          s2_load_s;
  logic          accept_s;
  logic          ovfl_xfer_s;

  // Handshake: in_ready looks through to out_ready so a full pipe can still advance
  always_comb begin
    s2_load_s   = !out_valid || out_ready;
    in_ready    = !s1_valid_r || s2_load_s;
    accept_s    = in_valid && in_ready;
    ovfl_xfer_s = out_valid && out_ready && (|lane_ovfl);
  end

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    psa_lane #(.LANE_W(LANE_W)) u_lane (
      .a    (s1_a_r[gi*LANE_W +: LANE_W]),
      .b    (s1_b_r[gi*LANE_W +: LANE_W]),
      .sub  (s1_sub_r),
      .sat  (s1_sat_r),
      .res  (res_s[gi*LANE_W +: LANE_W]),
      .ovfl (ovfl_s[gi])
    );
  end

  // Stage 1 operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_sub_r   <= 1'b0;
      s1_sat_r   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= a;
      s1_b_r     <= b;
      s1_sub_r   <= sub;
      s1_sat_r   <= sat;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 result register; frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      lane_ovfl <= '0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        sum       <= res_s;
        lane_ovfl <= ovfl_s;
      end
    end
  end

  // Sticky error: a set in the same cycle as clr_err takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (ovfl_xfer_s) begin
      error <= 1'b1;
    end else if (clr_err) begin
      error <= 1'b0;
    end
  end

`ifdef PSA_PIPE_OVFL_CNT_EN
  // Overflow-transfer counter; clear-with-increment lands on 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfl_cnt <= 16'd0;
    end else if (ovfl_xfer_s) begin
      if (clr_err) begin
        ovfl_cnt <= 16'd1;
      end else if (ovfl_cnt != 16'hFFFF) begin
        ovfl_cnt <= ovfl_cnt + 16'd1;
      end
    end else if (clr_err) begin
      ovfl_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_psa_pipe.sv
// Self-checking bench for psa_pipe (LANE_W=4, LANES=4): directed cases plus random traffic
// compared against a queue-based arithmetic model.
module tb_psa_pipe;

  localparam int LW = 4;
  localparam int NL = 4;
  localparam int W  = LW * NL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          sub = 1'b0;
  logic          sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic [NL-1:0] lane_ovfl;
  logic          clr_err = 1'b0;
  logic          error;
`ifdef PSA_PIPE_OVFL_CNT_EN
  logic [15:0]   ovfl_cnt;
`endif

  psa_pipe #(.LANE_W(LW), .LANES(NL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .lane_ovfl (lane_ovfl),
    .clr_err   (clr_err),
    .error     (error)
`ifdef PSA_PIPE_OVFL_CNT_EN
    ,
    .ovfl_cnt  (ovfl_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: per-lane signed arithmetic in plain integers
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic s, input logic t,
                                output logic [W-1:0] r, output logic [NL-1:0] o);
    int maxv, minv;
    maxv = (1 << (LW - 1)) - 1;
    minv = -(1 << (LW - 1));
    for (int i = 0; i < NL; i++) begin
      int sa, sb, rr;
      logic [LW-1:0] la, lb;
      la = av[i*LW +: LW];
      lb = bv[i*LW +: LW];
      sa = int'($signed(la));
      sb = int'($signed(lb));
      rr = s ? sa - sb : sa + sb;
      o[i] = (rr > maxv) || (rr < minv);
      if (o[i] && t) rr = (sa >= 0) ? maxv : minv;
      r[i*LW +: LW] = rr[LW-1:0];
    end
  endfunction

  typedef struct {
    logic [W-1:0]  r;
    logic [NL-1:0] o;
  } exp_t;

  exp_t q[$];
  logic err_m = 1'b0;
  logic [15:0] cnt_m = 16'd0;
  logic held = 1'b0;
  logic [W-1:0] hs;
  logic [NL-1:0] ho;

  // Compare process: everything sampled on the falling edge, ahead of the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      err_m = 1'b0;
      cnt_m = 16'd0;
      held  = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      logic set;
      set = 1'b0;
      chk("error", error, err_m);
`ifdef PSA_PIPE_OVFL_CNT_EN
      chk("ovfl_cnt", ovfl_cnt, cnt_m);
`endif
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, hs);
        chk("hold_ovfl", lane_ovfl, ho);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", sum, e.r);
          chk("lane_ovfl", lane_ovfl, e.o);
          set = |e.o;
        end
      end
      err_m = set ? 1'b1 : (clr_err ? 1'b0 : err_m);
      if (set && clr_err) cnt_m = 16'd1;
      else if (set) cnt_m = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 16'd1;
      else if (clr_err) cnt_m = 16'd0;
      if (in_valid && in_ready) begin
        exp_t e;
        model(a, b, sub, sat, e.r, e.o);
        q.push_back(e);
      end
      held = out_valid && !out_ready;
      hs = sum;
      ho = lane_ovfl;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for up to budget cycles; in_valid drops after acceptance or expiry
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                      input logic t, input int budget, output bit ok);
    a = av; b = bv; sub = s; sat = t; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Single beat through an empty pipe: checks latency and the literal result
  task automatic run_one(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic t,
                         input logic [W-1:0] es, input logic [NL-1:0] eo);
    bit ok;
    out_ready = 1'b1;
    send(av, bv, s, t, 4, ok);
    chk({nm, "_accept"}, ok, 1);
    chk({nm, "_lat1"}, out_valid, 0);
    tick();
    chk({nm, "_lat2"}, out_valid, 1);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_ovfl"}, lane_ovfl, eo);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int oc;
    logic [W-1:0] mr;
    logic [NL-1:0] mo;

    // Pin the model with hand-computed values
    model(16'h1234, 16'h1111, 1'b0, 1'b0, mr, mo);
    chk("model_add", {mr, mo}, {16'h2345, 4'h0});
    model(16'h7777, 16'h1111, 1'b0, 1'b1, mr, mo);
    chk("model_sat", {mr, mo}, {16'h7777, 4'hF});
    model(16'h8000, 16'h1111, 1'b1, 1'b1, mr, mo);
    chk("model_ssub", {mr, mo}, {16'h8FFF, 4'h8});

    tick();
    chk("reset_sum", sum, 0);
    chk("reset_error", error, 0);
    tick();
    rst = 1'b0;
    tick();

    run_one("add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 4'h0);
    chk("add_err", error, 0);
    run_one("wrap", 16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 4'hF);
    chk("wrap_err", error, 1);
    run_one("sat", 16'h7777, 16'h1111, 1'b0, 1'b1, 16'h7777, 4'hF);
    run_one("ssub", 16'h8000, 16'h1111, 1'b1, 1'b1, 16'h8FFF, 4'h8);

    // Sticky clear race
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err", error, 0);
    send(16'h7777, 16'h1111, 1'b0, 1'b0, 4, ok);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("race_err", error, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("race_clr", error, 0);

    // Backpressure: two beats fill the pipe, the third waits
    oc = out_cnt;
    out_ready = 1'b0;
    send(16'h1111, 16'h0101, 1'b0, 1'b0, 4, ok);
    chk("bp_acc1", ok, 1);
    send(16'h2222, 16'h0202, 1'b1, 1'b0, 4, ok);
    chk("bp_acc2", ok, 1);
    send(16'h3333, 16'h0303, 1'b0, 1'b1, 2, ok);
    chk("bp_acc3_blocked", ok, 0);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    send(16'h3333, 16'h0303, 1'b0, 1'b1, 4, ok);
    chk("bp_acc3", ok, 1);
    repeat (4) tick();
    chk("bp_outs", out_cnt - oc, 3);
    chk("bp_drained", q.size(), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      sat = 1'($urandom);
      clr_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", q.size(), 0);

    // Reset with both stages full and error set
    run_one("pre_rst", 16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 4'h8);
    chk("pre_rst_err", error, 1);
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 4, ok);
    send(16'h5555, 16'h1111, 1'b1, 1'b0, 4, ok);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_err", error, 0);
    chk("rst_ir", in_ready, 1);
    tick();
    rst = 1'b0;
    oc = out_cnt;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("no_stale", out_cnt - oc, 0);
    chk("no_stale_ov", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
